alu_fpga_ctrl: RTL and testbench

- Parametrised board-level controller for bench-testing the ALU on the DE2 FPGA.
- Replaces free-running switch sampling with a keyed operand-entry state machine:
  - debounced pushbuttons
  - registered result and flags
  - selectable display view (result, A or B) over a configurable number of hex digits
- Sits between the board pins and the alu instance; the top wrapper wires it to the alu and to the HEX/LEDR pins.

---
 rtl/alu_fpga_ctrl_if.sv | 22 ++
 rtl/alu_fpga_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alu_fpga_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_fpga_ctrl_if.sv
// Operand/opcode bus between alu_fpga_ctrl (master) and the alu under test (slave).
interface alu_fpga_ctrl_if #(
  parameter int WORD_W = 32
);
  logic [3:0]        alu_op;
  logic [WORD_W-1:0] alu_a;
  logic [WORD_W-1:0] alu_b;
  logic [WORD_W-1:0] alu_out;
  logic              alu_nf;
  logic              alu_vf;
  logic              alu_zf;

  modport master (
    output alu_op, alu_a, alu_b,
    input  alu_out, alu_nf, alu_vf, alu_zf
  );

  modport slave (
    input  alu_op, alu_a, alu_b,
    output alu_out, alu_nf, alu_vf, alu_zf
  );
endinterface

// File: rtl/alu_fpga_ctrl.sv
// DE2 bench controller for the alu: debounced keys, keyed A/B/op entry FSM, registered result/flags, hex view.
// Optional macro ALU_FPGA_BLANK_EN enables leading-zero blanking of the hex digits.
module alu_fpga_ctrl #(
  parameter int WORD_W          = 32,
  parameter int DIGITS          = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  nRST,
  input  logic [3:0]            KEY,
  input  logic [17:0]           SW,
  alu_fpga_ctrl_if.master       alu_bus,
  output logic [7*DIGITS-1:0]   hex_segs,
  output logic [17:0]           LEDR
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] VIEW_RES = 2'd0;
  localparam logic [1:0] VIEW_A   = 2'd1;
  localparam logic [1:0] VIEW_B   = 2'd2;

  // One-hot encoding doubles as the LEDR[17:13] state lamps.
  typedef enum logic [4:0] {
    ST_ENTER_A  = 5'b10000,
    ST_ENTER_B  = 5'b01000,
    ST_ENTER_OP = 5'b00100,
    ST_EXEC     = 5'b00010,
    ST_SHOW     = 5'b00001
  } state_t;

  genvar gi;

  logic [3:0] w_press;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic             r_meta;
      logic             r_sync;
      logic             r_level;
      logic             r_press;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
          r_meta  <= 1'b1;
          r_sync  <= 1'b1;
          r_level <= 1'b1;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_meta  <= KEY[gi];
          r_sync  <= r_meta;
          r_press <= 1'b0;
          if (r_sync != r_level) begin
            if (r_cnt == CNT_LAST) begin
              r_level <= r_sync;
              r_cnt   <= '0;
              r_press <= r_level & ~r_sync;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  // Clear beats enter beats view; KEY1 is reserved.
  logic w_clr;
  logic w_ent;
  logic w_view;
  assign w_clr  = w_press[3];
  assign w_ent  = w_press[0] & ~w_press[3];
  assign w_view = w_press[2] & ~w_press[3] & ~w_press[0];

  logic [WORD_W-1:0] w_capture;
  generate
    if (WORD_W > 16) begin : g_fill
      assign w_capture = {{(WORD_W-16){SW[16]}}, SW[15:0]};
    end else begin : g_trunc
      assign w_capture = SW[WORD_W-1:0];
    end
  endgenerate

  state_t r_state;
  state_t w_state_next;
  logic   w_load_a;
  logic   w_load_b;
  logic   w_load_op;
  logic   w_load_res;

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_ENTER_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_op    = 1'b0;
    w_load_res   = 1'b0;
    if (w_clr) begin
      w_state_next = ST_ENTER_A;
    end else begin
      case (r_state)
        ST_ENTER_A: begin
          if (w_ent) begin
            w_load_a     = 1'b1;
            w_state_next = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (w_ent) begin
            w_load_b     = 1'b1;
            w_state_next = ST_ENTER_OP;
          end
        end
        ST_ENTER_OP: begin
          if (w_ent) begin
            w_load_op    = 1'b1;
            w_state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          w_load_res   = 1'b1;
          w_state_next = ST_SHOW;
        end
        ST_SHOW: begin
          if (w_ent) begin
            w_state_next = ST_ENTER_A;
          end
        end
        default: begin
          w_state_next = ST_ENTER_A;
        end
      endcase
    end
  end

  logic [1:0] r_view;
  logic [1:0] w_view_next;

  always_comb begin
    w_view_next = r_view;
    if (w_clr) begin
      w_view_next = VIEW_RES;
    end else if (w_view && (r_state != ST_EXEC)) begin
      case (r_view)
        VIEW_RES: w_view_next = VIEW_A;
        VIEW_A:   w_view_next = VIEW_B;
        default:  w_view_next = VIEW_RES;
      endcase
    end
  end

  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic [3:0]        r_op;
  logic [WORD_W-1:0] r_res;
  logic [2:0]        r_flags;

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_view  <= VIEW_RES;
    end else begin
      r_view <= w_view_next;
      if (w_clr) begin
        r_a     <= '0;
        r_b     <= '0;
        r_op    <= '0;
        r_res   <= '0;
        r_flags <= '0;
      end else begin
        if (w_load_a) begin
          r_a <= w_capture;
        end
        if (w_load_b) begin
          r_b <= w_capture;
        end
        if (w_load_op) begin
          r_op <= SW[3:0];
        end
        if (w_load_res) begin
          r_res   <= alu_bus.alu_out;
          r_flags <= {alu_bus.alu_vf, alu_bus.alu_zf, alu_bus.alu_nf};
        end
      end
    end
  end

  assign alu_bus.alu_a  = r_a;
  assign alu_bus.alu_b  = r_b;
  assign alu_bus.alu_op = r_op;

  logic [WORD_W-1:0]   w_sel;
  logic [31:0]         w_sel32;
  logic [4*DIGITS-1:0] w_disp;

  always_comb begin
    case (r_view)
      VIEW_A:  w_sel = r_a;
      VIEW_B:  w_sel = r_b;
      default: w_sel = r_res;
    endcase
  end

  assign w_sel32 = 32'(w_sel);
  assign w_disp  = w_sel32[4*DIGITS-1:0];

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic w_lit;
`ifdef ALU_FPGA_BLANK_EN
      if (gi == 0) begin : g_first
        assign w_lit = 1'b1;
      end else begin : g_upper
        assign w_lit = |w_disp[4*DIGITS-1:4*gi];
      end
`else
      assign w_lit = 1'b1;
`endif
      assign hex_segs[7*gi +: 7] = w_lit ? hex7(w_disp[4*gi +: 4]) : 7'b1111111;
    end
  endgenerate

  assign LEDR = {r_state, 7'b0, r_view, 1'b0, r_flags};

  // Reserved key and switch bits that some parameterisations leave unread.
  logic w_unused;
  assign w_unused = &{1'b0, w_press[1], SW, w_sel32};

endmodule

// File: tb/tb_alu_fpga_ctrl.sv
// Self-checking bench for alu_fpga_ctrl with an adder stub alu and a result scoreboard.
module tb_alu_fpga_ctrl;

  localparam int WORD_W = 32;
  localparam int DIGITS = 8;
  localparam int DEB    = 4;

  localparam logic [4:0] ST_A    = 5'b10000;
  localparam logic [4:0] ST_B    = 5'b01000;
  localparam logic [4:0] ST_OP   = 5'b00100;
  localparam logic [4:0] ST_EXEC = 5'b00010;
  localparam logic [4:0] ST_SHOW = 5'b00001;

  logic                CLOCK_50 = 1'b0;
  logic                nRST     = 1'b0;
  logic [3:0]          KEY      = 4'hF;
  logic [17:0]         SW       = '0;
  logic [7*DIGITS-1:0] hex_segs;
  logic [17:0]         LEDR;

  alu_fpga_ctrl_if #(.WORD_W(WORD_W)) alu_bus();

  assign alu_bus.alu_out = alu_bus.alu_a + alu_bus.alu_b;
  assign alu_bus.alu_nf  = alu_bus.alu_out[31];
  assign alu_bus.alu_zf  = (alu_bus.alu_out == 32'd0);
  assign alu_bus.alu_vf  = (alu_bus.alu_a[31] == alu_bus.alu_b[31]) &&
                           (alu_bus.alu_out[31] != alu_bus.alu_a[31]);

  alu_fpga_ctrl #(
    .WORD_W(WORD_W),
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .nRST(nRST),
    .KEY(KEY),
    .SW(SW),
    .alu_bus(alu_bus),
    .hex_segs(hex_segs),
    .LEDR(LEDR)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [16:0] a_sw;
    logic [16:0] b_sw;
    logic [3:0]  op;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[6];
  int   n_pass  = 0;
  int   n_total = 0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [55:0] exp_segs(input logic [31:0] v);
    logic [55:0] s;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s[7*i +: 7] = font[v[4*i +: 4]];
`ifdef ALU_FPGA_BLANK_EN
      if (i > 0 && (v >> (4*i)) == 32'd0) s[7*i +: 7] = 7'h7F;
`endif
    end
    return s;
  endfunction

  function automatic logic [31:0] cap(input logic [16:0] s);
    return {{16{s[16]}}, s[15:0]};
  endfunction

  task automatic press(input logic [3:0] mask, input int low_cycles);
    KEY = ~mask;
    repeat (low_cycles) @(negedge CLOCK_50);
    KEY = 4'hF;
    repeat (10) @(negedge CLOCK_50);
  endtask

  task automatic run_txn(input vec_t v);
    logic [31:0] prev_a;
    if (LEDR[17:13] == ST_SHOW) begin
      prev_a = alu_bus.alu_a;
      press(4'b0001, 8);
      check("show_to_a_retain", alu_bus.alu_a, prev_a);
    end
    check("txn_start_state", LEDR[17:13], ST_A);
    SW = {1'b0, v.a_sw};
    press(4'b0001, 8);
    check("enter_a", alu_bus.alu_a, cap(v.a_sw));
    check("state_b", LEDR[17:13], ST_B);
    SW = {1'b0, v.b_sw};
    press(4'b0001, 8);
    check("enter_b", alu_bus.alu_b, cap(v.b_sw));
    check("state_op", LEDR[17:13], ST_OP);
    sb.push_back('{res: v.res, flags: v.flags});
    SW = {14'h1555, v.op};
    press(4'b0001, 8);
    check("sb_pending", sb.size(), 0);
    check("state_show", LEDR[17:13], ST_SHOW);
    check("alu_op", alu_bus.alu_op, v.op);
  endtask

  // Scoreboard: pop and compare on each EXEC -> SHOW transition.
  initial begin
    logic [4:0] prev_state;
    int         exec_len;
    sb_t        e;
    prev_state = ST_A;
    exec_len   = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!nRST) begin
        prev_state = ST_A;
        exec_len   = 0;
      end else begin
        if (LEDR[14]) exec_len++;
        if (LEDR[13] && prev_state == ST_EXEC) begin
          check("exec_len", exec_len, 1);
          if (sb.size() == 0) begin
            check("sb_unexpected_show", 1, 0);
          end else begin
            e = sb.pop_front();
            check("sb_display", hex_segs, exp_segs(e.res));
            check("sb_flags", LEDR[2:0], e.flags);
          end
          exec_len = 0;
        end
        prev_state = LEDR[17:13];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a_sw: 17'h00005, b_sw: 17'h00003, op: 4'h0, res: 32'h00000008, flags: 3'b000};
    vecs[1] = '{a_sw: 17'h1FFFF, b_sw: 17'h00001, op: 4'h1, res: 32'h00000000, flags: 3'b010};
    vecs[2] = '{a_sw: 17'h1FFF0, b_sw: 17'h00005, op: 4'h2, res: 32'hFFFFFFF5, flags: 3'b001};
    vecs[3] = '{a_sw: 17'h18000, b_sw: 17'h18000, op: 4'h7, res: 32'hFFFF0000, flags: 3'b001};
    vecs[4] = '{a_sw: 17'h0FFFF, b_sw: 17'h00001, op: 4'hA, res: 32'h00010000, flags: 3'b000};
    vecs[5] = '{a_sw: 17'h0FFFF, b_sw: 17'h0FFFF, op: 4'hF, res: 32'h0001FFFE, flags: 3'b000};

    repeat (3) @(negedge CLOCK_50);
    check("reset_ledr", LEDR, 18'h20000);
    check("reset_hex", hex_segs, exp_segs(32'd0));
    nRST = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    press(4'b0010, 8);
    check("key1_no_effect", LEDR[17:13], ST_A);

    press(4'b0001, 3);
    check("glitch_ignored", LEDR[17:13], ST_A);
    press(4'b0001, 8);
    check("press_one_step", LEDR[17:13], ST_B);
    repeat (10) @(negedge CLOCK_50);
    check("press_still_b", LEDR[17:13], ST_B);
    press(4'b1000, 8);
    check("clear_to_a", LEDR[17:13], ST_A);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    run_txn('{a_sw: 17'h01234, b_sw: 17'h0ABCD, op: 4'h3, res: 32'h0000BE01, flags: 3'b000});
    press(4'b0100, 8);
    check("view_a_hex", hex_segs, exp_segs(32'h00001234));
    check("view_a_led", LEDR[5:4], 2'd1);
    press(4'b0100, 8);
    check("view_b_hex", hex_segs, exp_segs(32'h0000ABCD));
    check("view_b_led", LEDR[5:4], 2'd2);
    press(4'b0100, 8);
    check("view_res_hex", hex_segs, exp_segs(32'h0000BE01));
    check("view_res_led", LEDR[5:4], 2'd0);

    press(4'b0100, 8);
    check("pre_clr_view", LEDR[5:4], 2'd1);
    SW = 18'h00077;
    press(4'b1001, 8);
    check("clr_ent_state", LEDR[17:13], ST_A);
    check("clr_ent_a", alu_bus.alu_a, 32'd0);
    check("clr_ent_b", alu_bus.alu_b, 32'd0);
    check("clr_ent_op", alu_bus.alu_op, 4'd0);
    check("clr_ent_ledr", LEDR, 18'h20000);
    check("clr_ent_hex", hex_segs, exp_segs(32'd0));

    SW = 18'h00009;
    press(4'b0001, 8);
    check("mid_state_b", LEDR[17:13], ST_B);
    check("mid_a", alu_bus.alu_a, 32'd9);
    KEY = 4'b1110;
    repeat (3) @(negedge CLOCK_50);
    #5 nRST = 1'b0;
    #1;
    check("async_rst_led17", LEDR[17], 1'b1);
    check("async_rst_ledr", LEDR, 18'h20000);
    check("async_rst_a", alu_bus.alu_a, 32'd0);
    check("async_rst_hex", hex_segs, exp_segs(32'd0));
    KEY = 4'hF;
    @(negedge CLOCK_50);
    nRST = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    check("post_rst_state", LEDR[17:13], ST_A);
    check("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
